// File: rtl/cpu_mmu_wca_seq.sv
// Cache tag-write sequencer: drives the PPN->CPN buffer enable (WCA_n) and the tag RAM
// strobe, arbitrating single-entry fills against a full invalidate sweep.
module cpu_mmu_wca_seq #(
    parameter int IDX_W    = 10,
    parameter int TAG_W    = 14,
    parameter int WR_PULSE = 2
) (
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic             fill_req,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_ppn,
    input  logic             clr_req,
    output logic             fill_ack,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             WCA_n,
    output logic             CWR_n,
    output logic [IDX_W-1:0] cadr,
    output logic             cvalid,
    output logic [TAG_W-1:0] tag_ppn
);

    typedef enum logic [2:0] {
        IDLE,
        F_SETUP,
        F_WR,
        F_HOLD,
        C_SETUP,
        C_WR,
        C_HOLD
    } seqState_t;

    localparam logic [2:0]       PULSE_LAST = 3'(WR_PULSE - 1);
    localparam logic [IDX_W-1:0] CNT_LAST   = '1;

    seqState_t        state, stateNxt;
    logic [2:0]       wcnt, wcntNxt;
    logic [IDX_W-1:0] cnt, cntNxt;
    logic             clrPend, clrPendNxt;

    logic             fillAckNxt;
    logic             clrBusyNxt;
    logic             clrDoneNxt;
    logic             wcaNxt;
    logic             cwrNxt;
    logic [IDX_W-1:0] cadrNxt;
    logic             cvalidNxt;
    logic [TAG_W-1:0] tagNxt;

    // Outputs are computed for the state being entered and registered with it, so every
    // output is a flop and the strobe edges line up with the state boundaries.
    always_comb begin
        stateNxt   = state;
        wcntNxt    = wcnt;
        cntNxt     = cnt;
        clrPendNxt = clrPend;
        cadrNxt    = cadr;
        cvalidNxt  = cvalid;
        tagNxt     = tag_ppn;
        wcaNxt     = 1'b1;
        cwrNxt     = 1'b1;
        fillAckNxt = 1'b0;
        clrDoneNxt = 1'b0;

        case (state)
            IDLE: begin
                if (clr_req || clrPend) begin
                    stateNxt   = C_SETUP;
                    cntNxt     = '0;
                    cadrNxt    = '0;
                    cvalidNxt  = 1'b0;
                    clrPendNxt = 1'b0;
                end else if (fill_req) begin
                    stateNxt  = F_SETUP;
                    cadrNxt   = fill_idx;
                    tagNxt    = fill_ppn;
                    cvalidNxt = 1'b1;
                    wcaNxt    = 1'b0;
                end
            end
            F_SETUP: begin
                stateNxt = F_WR;
                wcntNxt  = '0;
                wcaNxt   = 1'b0;
                cwrNxt   = 1'b0;
            end
            F_WR: begin
                wcaNxt = 1'b0;
                if (wcnt == PULSE_LAST) begin
                    stateNxt   = F_HOLD;
                    fillAckNxt = 1'b1;
                end else begin
                    wcntNxt = wcnt + 3'd1;
                    cwrNxt  = 1'b0;
                end
            end
            F_HOLD: begin
                stateNxt = IDLE;
            end
            C_SETUP: begin
                stateNxt = C_WR;
                wcntNxt  = '0;
                cwrNxt   = 1'b0;
            end
            C_WR: begin
                if (wcnt == PULSE_LAST) begin
                    stateNxt   = C_HOLD;
                    clrDoneNxt = (cnt == CNT_LAST);
                end else begin
                    wcntNxt = wcnt + 3'd1;
                    cwrNxt  = 1'b0;
                end
            end
            C_HOLD: begin
                if (cnt == CNT_LAST) begin
                    stateNxt = IDLE;
                end else begin
                    stateNxt = C_SETUP;
                    cntNxt   = cnt + IDX_W'(1);
                    cadrNxt  = cnt + IDX_W'(1);
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        // A clear arriving mid-fill waits for the fill to finish; one arriving mid-sweep is dropped.
        if (clr_req && (state inside {F_SETUP, F_WR, F_HOLD})) begin
            clrPendNxt = 1'b1;
        end

        clrBusyNxt = clrPendNxt || (stateNxt inside {C_SETUP, C_WR, C_HOLD});
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            wcnt     <= '0;
            cnt      <= '0;
            clrPend  <= 1'b0;
            fill_ack <= 1'b0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            WCA_n    <= 1'b1;
            CWR_n    <= 1'b1;
            cadr     <= '0;
            cvalid   <= 1'b0;
            tag_ppn  <= '0;
        end else begin
            state    <= stateNxt;
            wcnt     <= wcntNxt;
            cnt      <= cntNxt;
            clrPend  <= clrPendNxt;
            fill_ack <= fillAckNxt;
            clr_busy <= clrBusyNxt;
            clr_done <= clrDoneNxt;
            WCA_n    <= wcaNxt;
            CWR_n    <= cwrNxt;
            cadr     <= cadrNxt;
            cvalid   <= cvalidNxt;
            tag_ppn  <= tagNxt;
        end
    end

endmodule

// File: tb/tb_cpu_mmu_wca_seq.sv
// Bench for cpu_mmu_wca_seq: directed and random fills/sweeps checked against a tag RAM
// model and cycle-count formulas; a second instance built with WR_PULSE=3 covers async reset.
module tb_cpu_mmu_wca_seq;

    localparam int IDX_W = 10;
    localparam int TAG_W = 14;
    localparam int WP    = 2;
    localparam int WP3   = 3;
    localparam int NENT  = 1 << IDX_W;
    localparam int SLOT  = 2 + WP;
    localparam int SWEEP = NENT * SLOT;

    logic             sysclk = 1'b0;
    logic             sys_rst_n;
    logic             fill_req, clr_req;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_ppn;
    logic             fill_ack, clr_busy, clr_done, WCA_n, CWR_n, cvalid;
    logic [IDX_W-1:0] cadr;
    logic [TAG_W-1:0] tag_ppn;

    logic             fillReq3, clrReq3;
    logic [IDX_W-1:0] fillIdx3;
    logic [TAG_W-1:0] fillPpn3;
    logic             ack3, busy3, done3, wca3, cwr3, cvalid3;
    logic [IDX_W-1:0] cadr3;
    logic [TAG_W-1:0] tag3;

    always #5 sysclk = ~sysclk;

    cpu_mmu_wca_seq #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WR_PULSE(WP)) dut (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n),
        .fill_req(fill_req), .fill_idx(fill_idx), .fill_ppn(fill_ppn), .clr_req(clr_req),
        .fill_ack(fill_ack), .clr_busy(clr_busy), .clr_done(clr_done),
        .WCA_n(WCA_n), .CWR_n(CWR_n), .cadr(cadr), .cvalid(cvalid), .tag_ppn(tag_ppn)
    );

    cpu_mmu_wca_seq #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WR_PULSE(WP3)) dut3 (
        .sysclk(sysclk), .sys_rst_n(sys_rst_n),
        .fill_req(fillReq3), .fill_idx(fillIdx3), .fill_ppn(fillPpn3), .clr_req(clrReq3),
        .fill_ack(ack3), .clr_busy(busy3), .clr_done(done3),
        .WCA_n(wca3), .CWR_n(cwr3), .cadr(cadr3), .cvalid(cvalid3), .tag_ppn(tag3)
    );

    // Tag RAM emulation: the CPN bus carries tag_ppn only while the buffer is enabled.
    logic             ramV [NENT];
    logic [TAG_W-1:0] ramT [NENT];
    logic             modV [NENT];
    logic [TAG_W-1:0] modT [NENT];
    logic [IDX_W+1:0] pulses [$];
    int               stableErr = 0;
    logic             cwrPrev = 1'b1, wcaPrev = 1'b1;
    logic [IDX_W-1:0] cadrPrev = '0;

    always @(posedge sysclk) begin
        if (!sys_rst_n) begin
            cwrPrev  <= 1'b1;
            wcaPrev  <= 1'b1;
            cadrPrev <= '0;
        end else begin
            if (!CWR_n) begin
                ramV[cadr] <= cvalid;
                ramT[cadr] <= WCA_n ? '0 : tag_ppn;
            end
            if (!CWR_n && cwrPrev) pulses.push_back({WCA_n, cvalid, cadr});
            if (!CWR_n && (WCA_n !== wcaPrev || cadr !== cadrPrev)) stableErr <= stableErr + 1;
            cwrPrev  <= CWR_n;
            wcaPrev  <= WCA_n;
            cadrPrev <= cadr;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < NENT; i++) begin
            modV[i] = 1'b0;
            modT[i] = '0;
        end
    endtask

    // Holds fill_req until fill_ack; tick k observes the k-th cycle after the sampling cycle.
    task automatic runFill(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] ppn,
                           output int ackAt, output logic [31:0] wcaMask, output logic [31:0] cwrMask,
                           output logic vldSeen, output logic [IDX_W-1:0] adrSeen,
                           output logic [TAG_W-1:0] tagSeen);
        fill_idx = idx;
        fill_ppn = ppn;
        fill_req = 1'b1;
        ackAt = -1;
        wcaMask = '0;
        cwrMask = '0;
        vldSeen = 1'b0;
        adrSeen = '0;
        tagSeen = '0;
        for (int k = 1; k <= 40 && ackAt < 0; k++) begin
            tick();
            if (k < 32) begin
                wcaMask[k] = !WCA_n;
                cwrMask[k] = !CWR_n;
            end
            if (!CWR_n) begin
                vldSeen = cvalid;
                adrSeen = cadr;
                tagSeen = tag_ppn;
            end
            if (fill_ack) begin
                ackAt = k;
                fill_req = 1'b0;
            end
        end
        fill_req = 1'b0;
        modV[idx] = 1'b1;
        modT[idx] = ppn;
    endtask

    task automatic runSweep(output int doneAt, output logic busyGap, output logic wcaLow);
        doneAt = -1;
        busyGap = 1'b0;
        wcaLow = 1'b0;
        clr_req = 1'b1;
        for (int k = 1; k <= SWEEP + 50 && doneAt < 0; k++) begin
            tick();
            clr_req = 1'b0;
            if (!clr_busy) busyGap = 1'b1;
            if (!WCA_n) wcaLow = 1'b1;
            if (clr_done) doneAt = k;
        end
        clr_req = 1'b0;
        modelClear();
    endtask

    int               ackAt, doneAt, ackCnt, doneCnt, p0, errs, firstAck;
    logic [31:0]      wcaMask, cwrMask, expW, expC;
    logic             vldSeen, busyGap, wcaLow, anyEvt, anyLow, busyMid, found;
    logic [IDX_W-1:0] adrSeen, idxA, idxB;
    logic [TAG_W-1:0] tagSeen, ppnA, ppnB;
    logic [IDX_W+1:0] pe;

    initial begin
        sys_rst_n = 1'b0;
        fill_req = 1'b0; clr_req = 1'b0; fill_idx = '0; fill_ppn = '0;
        fillReq3 = 1'b0; clrReq3 = 1'b0; fillIdx3 = '0; fillPpn3 = '0;
        repeat (3) tick();
        sys_rst_n = 1'b1;

        // Reset state and quiet idle
        anyEvt = 1'b0;
        anyLow = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fill_ack || clr_done || clr_busy) anyEvt = 1'b1;
            if (!WCA_n || !CWR_n) anyLow = 1'b1;
        end
        chk("rst_wca_n", 32'(WCA_n), 1);
        chk("rst_cwr_n", 32'(CWR_n), 1);
        chk("rst_cadr", 32'(cadr), 0);
        chk("rst_cvalid", 32'(cvalid), 0);
        chk("rst_tag_ppn", 32'(tag_ppn), 0);
        chk("rst_no_events", 32'(anyEvt), 0);
        chk("rst_no_strobes", 32'(anyLow), 0);
        chk("rst_busy3", 32'(busy3), 0);

        // Single directed fill
        runFill(10'h155, 14'h2A5F, ackAt, wcaMask, cwrMask, vldSeen, adrSeen, tagSeen);
        expW = '0;
        expC = '0;
        for (int k = 1; k <= SLOT; k++) expW[k] = 1'b1;
        for (int k = 2; k <= 1 + WP; k++) expC[k] = 1'b1;
        chk("fill_ack_latency", ackAt, SLOT);
        chk("fill_wca_window", wcaMask, expW);
        chk("fill_cwr_window", cwrMask, expC);
        chk("fill_cadr", 32'(adrSeen), 32'h155);
        chk("fill_tag_ppn", 32'(tagSeen), 32'h2A5F);
        chk("fill_cvalid", 32'(vldSeen), 1);
        tick();
        chk("fill_idle_wca_n", 32'(WCA_n), 1);
        chk("fill_ack_one_cycle", 32'(fill_ack), 0);
        chk("fill_ram_entry", 32'({ramV[10'h155], ramT[10'h155]}), 32'({1'b1, 14'h2A5F}));

        // Full invalidate sweep
        p0 = pulses.size();
        runSweep(doneAt, busyGap, wcaLow);
        chk("sweep_done_at", doneAt, SWEEP);
        chk("sweep_busy_held", 32'(busyGap), 0);
        chk("sweep_wca_n_high", 32'(wcaLow), 0);
        tick();
        chk("sweep_busy_drop", 32'(clr_busy), 0);
        chk("sweep_done_one_cycle", 32'(clr_done), 0);
        chk("sweep_pulse_count", pulses.size() - p0, NENT);
        errs = 0;
        for (int i = 0; i < NENT && p0 + i < pulses.size(); i++) begin
            pe = pulses[p0 + i];
            if (pe !== {1'b1, 1'b0, IDX_W'(i)}) errs++;
        end
        chk("sweep_pulse_order", errs, 0);

        // Clear and fill in the same idle cycle: sweep first, then the fill
        idxA = 10'h3C7;
        ppnA = TAG_W'($urandom);
        fill_idx = idxA; fill_ppn = ppnA; fill_req = 1'b1; clr_req = 1'b1;
        ackAt = -1;
        doneAt = -1;
        for (int k = 1; k <= SWEEP + 60 && ackAt < 0; k++) begin
            tick();
            clr_req = 1'b0;
            if (clr_done && doneAt < 0) doneAt = k;
            if (fill_ack) begin
                ackAt = k;
                fill_req = 1'b0;
            end
        end
        fill_req = 1'b0;
        modelClear();
        modV[idxA] = 1'b1;
        modT[idxA] = ppnA;
        chk("simul_done_at", doneAt, SWEEP);
        chk("simul_ack_at", ackAt, SWEEP + 1 + SLOT);
        tick();
        tick();
        chk("simul_ram_entry", 32'({ramV[idxA], ramT[idxA]}), 32'({1'b1, ppnA}));

        // Clear during fill write, a second clear mid-sweep, and a fill withdrawn mid-sweep
        idxA = IDX_W'($urandom_range(0, NENT - 1));
        ppnA = TAG_W'($urandom);
        idxB = IDX_W'($urandom_range(0, NENT - 1));
        ppnB = TAG_W'($urandom);
        fill_idx = idxA; fill_ppn = ppnA; fill_req = 1'b1;
        ackAt = -1; doneAt = -1; ackCnt = 0; doneCnt = 0; busyMid = 1'b0;
        for (int k = 1; k <= 2 * SWEEP + 400; k++) begin
            tick();
            clr_req = 1'b0;
            if (k == 3) busyMid = clr_busy;
            if (fill_ack) begin
                ackCnt++;
                if (ackAt < 0) ackAt = k;
                fill_req = 1'b0;
            end
            if (clr_done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = k;
            end
            if (k == 2 || k == 250) clr_req = 1'b1;
            if (k == 350) begin
                fill_idx = idxB; fill_ppn = ppnB; fill_req = 1'b1;
            end
            if (k == 356) fill_req = 1'b0;
        end
        modelClear();
        chk("midfill_busy_next", 32'(busyMid), 1);
        chk("midfill_ack_at", ackAt, SLOT);
        chk("midfill_ack_count", ackCnt, 1);
        chk("midfill_done_at", doneAt, SLOT + 1 + SWEEP);
        chk("midfill_done_count", doneCnt, 1);

        // Random fills
        for (int n = 0; n < 20; n++) begin
            repeat (1 + $urandom_range(0, 2)) tick();
            idxA = IDX_W'($urandom_range(0, NENT - 1));
            ppnA = TAG_W'($urandom);
            runFill(idxA, ppnA, ackAt, wcaMask, cwrMask, vldSeen, adrSeen, tagSeen);
            chk("rnd_fill_latency", ackAt, SLOT);
            chk("rnd_fill_cadr", 32'(adrSeen), 32'(idxA));
        end
        tick();

        // fill_req still high after fill_ack starts a new fill
        idxA = IDX_W'($urandom_range(0, NENT - 1));
        ppnA = TAG_W'($urandom);
        idxB = IDX_W'($urandom_range(0, NENT - 1));
        ppnB = TAG_W'($urandom);
        fill_idx = idxA; fill_ppn = ppnA; fill_req = 1'b1;
        firstAck = -1;
        ackAt = -1;
        for (int k = 1; k <= 40 && ackAt < 0; k++) begin
            tick();
            if (fill_ack) begin
                if (firstAck < 0) begin
                    firstAck = k;
                    fill_idx = idxB;
                    fill_ppn = ppnB;
                end else begin
                    ackAt = k;
                    fill_req = 1'b0;
                end
            end
        end
        fill_req = 1'b0;
        modV[idxA] = 1'b1;
        modT[idxA] = ppnA;
        modV[idxB] = 1'b1;
        modT[idxB] = ppnB;
        chk("b2b_second_ack_gap", ackAt - firstAck, 1 + SLOT);
        repeat (3) tick();

        errs = 0;
        for (int i = 0; i < NENT; i++) begin
            if (ramV[i] !== modV[i] || ramT[i] !== modT[i]) errs++;
        end
        chk("ram_contents", errs, 0);
        chk("strobe_stability", stableErr, 0);

        // Async reset in the middle of a sweep write (WR_PULSE=3 instance)
        clrReq3 = 1'b1;
        tick();
        clrReq3 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 * NENT && !found; k++) begin
            if (cadr3 == 10'h200 && !cwr3) found = 1'b1;
            else tick();
        end
        chk("rst3_reached_c_wr", 32'(found), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst3_cwr_n_async", 32'(cwr3), 1);
        chk("rst3_wca_n_async", 32'(wca3), 1);
        chk("rst3_busy_async", 32'(busy3), 0);
        chk("rst3_cadr_async", 32'(cadr3), 0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        anyEvt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy3 || done3 || !cwr3 || !wca3) anyEvt = 1'b1;
        end
        chk("rst3_idle_after", 32'(anyEvt), 0);
        clrReq3 = 1'b1;
        tick();
        clrReq3 = 1'b0;
        chk("rst3_restart_busy", 32'(busy3), 1);
        chk("rst3_restart_cadr", 32'(cadr3), 0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (!cwr3) found = 1'b1;
            else tick();
        end
        chk("rst3_first_strobe", 32'(found), 1);
        chk("rst3_first_strobe_cadr", 32'(cadr3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_mmu_wca_seq.md
Name: cpu_mmu_wca_seq

Overview:
Sequencer for the cache tag-write path (sheet 31 PPN→CPN buffer).
- Drives WCA_n, which enables the buffer that presents the physical page number onto the cache page-number bus.
- Drives the cache tag RAM write strobe and index.
- Arbitrates single-entry fills from the miss logic against a full cache-clear sweep that writes every entry invalid.

Parameters:
IDX_W, 10, cache index width (1024 entries)
TAG_W, 14, page-number width (PPN bits 23:10)
WR_PULSE, 2, tag RAM write-strobe width in clocks (legal 1..7)

Ports:
sysclk  in  1  system clock, all logic rising-edge
sys_rst_n  in  1  asynchronous active-low reset
fill_req  in  1  level request to write one tag entry; held until fill_ack
fill_idx  in  IDX_W  cache index for fill
fill_ppn  in  TAG_W  page number for fill; passed through to the latched tag bus
clr_req  in  1  one-cycle pulse: start invalidate sweep
fill_ack  out  1  one-cycle pulse: fill written
clr_busy  out  1  sweep in progress or pending
clr_done  out  1  one-cycle pulse: sweep finished
WCA_n  out  1  active-low buffer enable (PPN onto CPN bus)
CWR_n  out  1  active-low tag RAM write strobe
cadr  out  IDX_W  tag RAM index
cvalid  out  1  valid bit written with the tag
tag_ppn  out  TAG_W  latched fill_ppn feeding the buffer inputs

Behaviour:
- All outputs are registered.
- Reset (async, any state, mid-write included):
  - WCA_n=1, CWR_n=1, cadr=0, cvalid=0, tag_ppn=0.
  - fill_ack=0, clr_done=0, clr_busy=0.
  - Pending clear is discarded; the FSM returns to IDLE.
- FSM states: IDLE, F_SETUP, F_WR, F_HOLD, C_SETUP, C_WR, C_HOLD.
- IDLE:
  - clr_req or clr_pend → C_SETUP with cnt=0. Clear wins over a simultaneous fill_req.
  - Otherwise fill_req → F_SETUP, latching fill_idx into cadr and fill_ppn into tag_ppn.
- F_SETUP (1 clk): WCA_n=0, cvalid=1, CWR_n=1.
- F_WR (WR_PULSE clks): WCA_n=0, CWR_n=0. Address and data are stable for the whole strobe.
- F_HOLD (1 clk): CWR_n=1, WCA_n=0, fill_ack=1. Next state is IDLE, where WCA_n=1.
- Fill latency: fill_ack is high exactly 2+WR_PULSE clocks after the first IDLE cycle that samples fill_req.
- Requester handshake: the requester drops fill_req in the cycle after fill_ack. If fill_req is still high in the IDLE cycle following F_HOLD, it is a new fill.
- fill_req dropped before acceptance: no action.
- C_SETUP (1 clk): WCA_n=1, so the buffer drives 0 onto CPN; cvalid=0, cadr=cnt, CWR_n=1.
- C_WR (WR_PULSE clks): CWR_n=0.
- C_HOLD (1 clk): CWR_n=1.
  - cnt==2^IDX_W-1 → clr_done=1, go to IDLE.
  - Otherwise cnt+1 → C_SETUP.
  - cnt is IDX_W bits; no wrap past the last entry.
- Sweep duration: 2^IDX_W × (2+WR_PULSE) clocks; 4096 at defaults.
- clr_req during a fill: sets clr_pend. The sweep starts from the IDLE cycle after F_HOLD, ahead of any fill_req. clr_busy=1 from the cycle after clr_req.
- clr_req during a sweep: ignored.
- fill_req during a sweep: not acknowledged until the sweep ends.
- clr_busy: high from the cycle after clr_req (or after acceptance) through the clr_done cycle; low the following cycle.
- Write-strobe counter: 3 bits, counts 0..WR_PULSE-1 in F_WR/C_WR.
- CWR_n is never low in a cycle where WCA_n or cadr changes.

Test Plan:
- Reset release, idle 10 clks → WCA_n=1, CWR_n=1, cadr=0, cvalid=0, no acks/done.
- Single fill: fill_idx=0x155, fill_ppn=0x2A5F held high → WCA_n low 4 clks, CWR_n low 2 clks (clks 2-3), cadr=0x155, tag_ppn=0x2A5F, cvalid=1, fill_ack at clk 4.
- Full sweep: clr_req pulse →
  - 1024 CWR_n pulses at cadr 0..1023 ascending, cvalid=0, WCA_n=1 throughout.
  - clr_done exactly 4096 clks after start; clr_busy drops next clk.
- Simultaneous: clr_req and fill_req in the same IDLE cycle → sweep first; fill_ack only after clr_done, then fill written with its values.
- clr_req mid-fill (during F_WR) → fill completes with fill_ack, sweep begins next IDLE cycle; second clr_req mid-sweep produces no extra sweep (single clr_done).
- Async reset asserted during C_WR at cadr=0x200, WR_PULSE=3 build → CWR_n and WCA_n go high without a clock, clr_busy=0. After release, the block is idle and a new clr_req restarts at cadr=0.
